// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush, freeze and a saturating back-pressure counter.
// Define PIPE_STAGE_SKID_EN for the two-entry skid build with a registered in_ready.
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  // state | meaning
  // EMPTY | ~mv: nothing held
  // ONE   | mv & ~sv: payload in main register only
  // TWO   | mv & sv: main register plus skid entry (skid build only)

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              mv;
  logic [DATA_W-1:0] md;
  logic              accept;
  logic              emit;

  assign out_valid = mv & ~freeze;
  assign out_data  = md;
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              sv;
  logic [DATA_W-1:0] sd;

  // Depends only on state and freeze, so there is no path from out_ready
  assign in_ready = ~sv & ~freeze;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mv <= 1'b0;
      md <= '0;
      sv <= 1'b0;
      sd <= '0;
    end else if (!freeze) begin
      if (flush) begin
        mv <= 1'b0;
        md <= '0;
        sv <= 1'b0;
        sd <= '0;
      end else if (sv) begin
        if (emit) begin
          md <= sd;
          sv <= 1'b0;
          sd <= '0;
        end
      end else if (mv) begin
        if (accept && emit) begin
          md <= in_data;
        end else if (accept) begin
          sv <= 1'b1;
          sd <= in_data;
        end else if (emit) begin
          mv <= 1'b0;
          md <= '0;
        end
      end else if (accept) begin
        mv <= 1'b1;
        md <= in_data;
      end
    end
  end
`else
  assign in_ready = (~mv | out_ready) & ~freeze;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mv <= 1'b0;
      md <= '0;
    end else if (!freeze) begin
      if (flush) begin
        mv <= 1'b0;
        md <= '0;
      end else if (accept) begin
        mv <= 1'b1;
        md <= in_data;
      end else if (emit) begin
        mv <= 1'b0;
        md <= '0;
      end
    end
  end
`endif

  // Flush leaves the counter alone; clr_cnt wins over an increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
    end else if (mv && !out_ready && !freeze && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: vector table, directed corner cases and a queue-based model.
module tb_pipe_stage_reg;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = 15;
`ifdef PIPE_STAGE_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              freeze = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              clr_cnt = 1'b0;
  logic [CNT_W-1:0]  stall_cnt;

  pipe_stage_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .clr_cnt(clr_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: an ordered queue of held payloads plus an integer counter
  logic [DATA_W-1:0] q[$];
  int                cnt_m = 0;

  function automatic logic m_ready();
    if (freeze) return 1'b0;
    if (DEPTH == 2) return (q.size() < 2);
    return (q.size() == 0) || out_ready;
  endfunction

  function automatic logic m_valid();
    return (q.size() > 0) && !freeze;
  endfunction

  function automatic logic [DATA_W-1:0] m_data();
    return (q.size() > 0) ? q[0] : '0;
  endfunction

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic sample_check();
    @(negedge clk);
    chk("model_out_valid", {63'd0, out_valid}, {63'd0, m_valid()});
    chk("model_out_data", out_data, m_data());
    chk("model_in_ready", {63'd0, in_ready}, {63'd0, m_ready()});
    chk("model_stall_cnt", {60'd0, stall_cnt}, DATA_W'(cnt_m));
  endtask

  task automatic advance();
    logic acc, emt, stall;
    @(posedge clk);
    if (rst) begin
      acc   = in_valid && m_ready();
      emt   = m_valid() && out_ready;
      stall = (q.size() > 0) && !out_ready && !freeze;
      if (clr_cnt) cnt_m = 0;
      else if (stall && cnt_m < CNT_MAX) cnt_m++;
      if (!freeze) begin
        if (flush) q.delete();
        else begin
          if (emt) void'(q.pop_front());
          if (acc) q.push_back(in_data);
        end
      end
    end
    #1;
  endtask

  task automatic step();
    sample_check();
    advance();
  endtask

  typedef struct {
    logic              iv;
    logic              ordy;
    logic [DATA_W-1:0] d;
    logic              eov;
    logic [DATA_W-1:0] eod;
    logic              eir;
    int                ecnt;
  } vec_t;

  vec_t tbl[8];

  initial begin
    // Back-pressure case with A=0xA, B=0xB, C=0xC from an empty stage
`ifdef PIPE_STAGE_SKID_EN
    tbl[0] = '{1'b1, 1'b0, 64'hA, 1'b0, 64'h0, 1'b1, 0};
    tbl[1] = '{1'b1, 1'b0, 64'hB, 1'b1, 64'hA, 1'b1, 0};
    tbl[2] = '{1'b1, 1'b0, 64'hC, 1'b1, 64'hA, 1'b0, 1};
    tbl[3] = '{1'b1, 1'b0, 64'hC, 1'b1, 64'hA, 1'b0, 2};
    tbl[4] = '{1'b1, 1'b1, 64'hC, 1'b1, 64'hA, 1'b0, 3};
    tbl[5] = '{1'b1, 1'b1, 64'hC, 1'b1, 64'hB, 1'b1, 3};
    tbl[6] = '{1'b0, 1'b1, 64'h0, 1'b1, 64'hC, 1'b1, 3};
    tbl[7] = '{1'b0, 1'b1, 64'h0, 1'b0, 64'h0, 1'b1, 3};
`else
    tbl[0] = '{1'b1, 1'b0, 64'hA, 1'b0, 64'h0, 1'b1, 0};
    tbl[1] = '{1'b1, 1'b0, 64'hB, 1'b1, 64'hA, 1'b0, 0};
    tbl[2] = '{1'b1, 1'b0, 64'hC, 1'b1, 64'hA, 1'b0, 1};
    tbl[3] = '{1'b1, 1'b0, 64'hC, 1'b1, 64'hA, 1'b0, 2};
    tbl[4] = '{1'b1, 1'b1, 64'hC, 1'b1, 64'hA, 1'b1, 3};
    tbl[5] = '{1'b0, 1'b1, 64'h0, 1'b1, 64'hC, 1'b1, 3};
    tbl[6] = '{1'b0, 1'b1, 64'h0, 1'b0, 64'h0, 1'b1, 3};
    tbl[7] = '{1'b0, 1'b1, 64'h0, 1'b0, 64'h0, 1'b1, 3};
`endif

    #2;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_out_data", out_data, 64'd0);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset_stall_cnt", {60'd0, stall_cnt}, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      in_valid  = tbl[i].iv;
      out_ready = tbl[i].ordy;
      in_data   = tbl[i].d;
      sample_check();
      chk($sformatf("tbl%0d_out_valid", i), {63'd0, out_valid}, {63'd0, tbl[i].eov});
      chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].eod);
      chk($sformatf("tbl%0d_in_ready", i), {63'd0, in_ready}, {63'd0, tbl[i].eir});
      chk($sformatf("tbl%0d_stall_cnt", i), {60'd0, stall_cnt}, DATA_W'(tbl[i].ecnt));
      advance();
    end

    // Streaming 1..20 with out_ready high
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    for (int i = 0; i < 21; i++) begin
      in_valid = (i < 20);
      in_data  = DATA_W'(i + 1);
      sample_check();
      if (i > 0) begin
        chk("stream_valid", {63'd0, out_valid}, 64'd1);
        chk("stream_data", out_data, DATA_W'(i));
      end
      advance();
    end

    // Freeze and flush together, then flush alone
    in_valid = 1'b1; out_ready = 1'b0; in_data = 64'h1111;
    step();
    in_data = 64'h2222;
    step();
    freeze = 1'b1; flush = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sample_check();
      chk("freeze_out_valid", {63'd0, out_valid}, 64'd0);
      chk("freeze_in_ready", {63'd0, in_ready}, 64'd0);
      chk("freeze_hold_data", out_data, 64'h1111);
      advance();
    end
    freeze = 1'b0;
    step();
    flush = 1'b0; in_valid = 1'b0;
    sample_check();
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_out_data", out_data, 64'd0);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    advance();

    // Counter saturation and clear while still stalled
    in_valid = 1'b1; in_data = 64'h3333; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    sample_check();
    chk("sat_stall_cnt", {60'd0, stall_cnt}, 64'd15);
    clr_cnt = 1'b1;
    advance();
    clr_cnt = 1'b0;
    sample_check();
    chk("clr_stall_cnt", {60'd0, stall_cnt}, 64'd0);
    advance();

    // Asynchronous reset with the stage full
    in_valid = 1'b1; in_data = 64'h4444;
    step();
    in_valid = 1'b0;
    step();
    step();
    #2 rst = 1'b0;
    q.delete(); cnt_m = 0;
    #1;
    chk("areset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("areset_out_data", out_data, 64'd0);
    chk("areset_stall_cnt", {60'd0, stall_cnt}, 64'd0);
    step();
    rst = 1'b1;
    sample_check();
    chk("areset_in_ready", {63'd0, in_ready}, 64'd1);
    advance();

    // Randomized traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      freeze    = ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      clr_cnt   = ($urandom_range(0, 19) == 0);
      in_data   = {$urandom, $urandom};
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
